// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor: a table of saturating counters indexed by fetch-PC bits.
// Define BP_GSHARE_EN to XOR a global history register into the lookup index (gshare).
module branch_predictor #(
  parameter  int ENTRIES = 16,
  parameter  int CTR_W   = 2,
  parameter  int CNT_W   = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      lk_pc_i,
  output logic             pred_taken_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  input  logic             upd_pred_i,
  output logic [CNT_W-1:0] upd_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [IDX_W-1:0] lk_idx;

  // Only the word-aligned index bits of the fetch PC select a counter.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc_i[31:IDX_W+2], lk_pc_i[1:0]};

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_i) begin
      ghr_d = IDX_W'({ghr_q, upd_taken_i});
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // The lookup uses the pre-shift history even when an update lands in the same cycle.
  assign lk_idx = lk_pc_i[IDX_W+1:2] ^ ghr_q;
`else
  assign lk_idx = lk_pc_i[IDX_W+1:2];
`endif

  // Counter table
  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic [CTR_W-1:0] ctr_d [ENTRIES];

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ctr_d = ctr_q;
    if (upd_valid_i) begin
      if (upd_taken_i && (ctr_q[upd_idx_i] != CTR_MAX)) begin
        ctr_d[upd_idx_i] = ctr_q[upd_idx_i] + 1'b1;
      end else if (!upd_taken_i && (ctr_q[upd_idx_i] != '0)) begin
        ctr_d[upd_idx_i] = ctr_q[upd_idx_i] - 1'b1;
      end
    end
  end

  // NOTE: the table is a flop array, not SRAM, so it can and must be reset like any register; no init sequencer is needed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values; that is what makes a same-cycle lookup read-old.
      ctr_q <= ctr_d;
    end
  end

  // Prediction registers travelling with IF/ID
  logic             pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0] pred_idx_q, pred_idx_d;

  always_comb begin
    pred_taken_d = pred_taken_q;
    pred_idx_d   = pred_idx_q;
    if (flush_i) begin
      pred_taken_d = 1'b0;
      pred_idx_d   = '0;
    end else if (!stall_i) begin
      pred_taken_d = ctr_q[lk_idx][CTR_W-1];
      pred_idx_d   = lk_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      pred_taken_q <= pred_taken_d;
      pred_idx_q   <= pred_idx_d;
    end
  end

  assign pred_taken_o = pred_taken_q;
  assign pred_idx_o   = pred_idx_q;

  // Saturating statistics
  logic [CNT_W-1:0] upd_cnt_q, upd_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    upd_cnt_d     = upd_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid_i) begin
      if (upd_cnt_q != CNT_MAX) begin
        upd_cnt_d = upd_cnt_q + 1'b1;
      end
      if ((upd_taken_i != upd_pred_i) && (mispred_cnt_q != CNT_MAX)) begin
        mispred_cnt_d = mispred_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      upd_cnt_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      upd_cnt_q     <= upd_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign upd_cnt_o     = upd_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch direction predictor for the 5-stage RISC-V pipeline; replaces the static not-taken assumption and the unconditional ID-stage flush on taken branches.
- Holds a table of ENTRIES saturating counters, indexed by fetch-PC bits.
- The prediction is registered alongside the IF/ID register, and the table is trained by the ID-stage branch resolution.
- Keeps saturating statistics counters for resolved branches and mispredicts.

Parameters:
ENTRIES, 16, number of counters; power of two, >= 2; IDX_W = log2(ENTRIES)
CTR_W, 2, saturating counter width, >= 2
CNT_W, 16, width of statistics counters

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
stall_i  input  1  hold the prediction registers (IF/ID stall)
flush_i  input  1  clear the prediction registers (IF/ID flush)
lk_pc_i  input  32  PC of the instruction being fetched
pred_taken_o  output  1  registered prediction for the instruction now in ID
pred_idx_o  output  IDX_W  registered table index used for that prediction
upd_valid_i  input  1  a branch resolved this cycle
upd_idx_i  input  IDX_W  index to train; the pred_idx_o value carried with that branch
upd_taken_i  input  1  actual branch outcome
upd_pred_i  input  1  prediction that was made for that branch
upd_cnt_o  output  CNT_W  resolved-branch count, saturating
mispred_cnt_o  output  CNT_W  mispredict count, saturating

Behaviour:
- Reset (rst_i=0, asynchronous, takes effect immediately regardless of clk_i):
  - every counter = 2^(CTR_W-1)-1 (weakly not-taken; 01 for CTR_W=2)
  - pred_taken_o=0, pred_idx_o=0, upd_cnt_o=0, mispred_cnt_o=0
  - GHR=0 when enabled
  - Reset mid-operation discards all training and all in-flight state.
- Lookup index: lk_idx = lk_pc_i[IDX_W+1:2], modified only by the optional feature.
- Prediction registers, updated on each rising edge, in priority order:
  - flush_i=1: pred_taken_o<=0, pred_idx_o<=0. Flush beats stall.
  - else stall_i=1: hold both outputs.
  - else: pred_taken_o<=MSB of counter[lk_idx]; pred_idx_o<=lk_idx.
  - Latency: 1 cycle from lk_pc_i to pred_taken_o.
- Training, on a rising edge with upd_valid_i=1 (unaffected by stall_i/flush_i):
  - upd_taken_i=1 and counter[upd_idx_i] < 2^CTR_W-1: increment.
  - upd_taken_i=0 and counter[upd_idx_i] > 0: decrement.
  - Otherwise the counter holds; no wrap-around in either direction.
- Simultaneous lookup and training of the same index: the lookup captures the pre-update counter value (read-old). The new value is visible from the following lookup.
- Statistics:
  - upd_cnt_o += 1 on every upd_valid_i.
  - mispred_cnt_o += 1 when upd_valid_i and upd_taken_i != upd_pred_i.
  - Both stick at 2^CNT_W-1.
- Only one training port exists, so only one update per cycle is possible.
- Table: flop array with asynchronous reset; no SRAM and no init sequencer.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - Adds an IDX_W-bit global history register (GHR), reset 0.
  - lk_idx = lk_pc_i[IDX_W+1:2] XOR GHR.
  - On upd_valid_i: GHR <= {GHR[IDX_W-2:0], upd_taken_i}.
  - A lookup in the same cycle as a GHR update uses the pre-shift GHR.
  - GHR is not affected by stall_i/flush_i.
- Undefined: no GHR flops; lk_idx is the PC bits only. Behaviour is otherwise identical.

Test Plan (all with ENTRIES=16, CTR_W=2 unless stated):
1. Reset check: drop rst_i between clock edges -> all outputs read 0 immediately. Release, then look up lk_pc_i=0x0000003C with no stall/flush -> one cycle later pred_taken_o=0, pred_idx_o=15, both counts 0.
2. Saturation: upd idx 3 taken x3 (ctr 01->10->11->11); look up 0x0C -> pred_taken_o=1. Then not-taken x1 -> still 1; not-taken x1 more -> 0. Then not-taken x2 -> ctr stays 00, no wrap.
3. Stall/flush: with pred_taken_o=1, stall_i=1 for 3 cycles while lk_pc_i changes -> output held at 1 and original idx. Then stall_i=1 and flush_i=1 -> pred_taken_o=0, pred_idx_o=0.
4. Stats: 5 updates with 3 having upd_pred_i!=upd_taken_i -> upd_cnt_o=5, mispred_cnt_o=3. With CNT_W=4, 20 mispredicting updates -> both counts stick at 15.
5. Read-old collision: ctr[5]=01; same cycle, update idx 5 taken and look up 0x14 -> pred_taken_o=0. Repeat the lookup next cycle -> 1.
6. BP_GSHARE_EN defined: updates taken, taken, not-taken on idx 0 -> GHR=0b0110. Look up 0x00 -> pred_idx_o=6. Same sequence without the macro -> pred_idx_o=0.
